// File: rtl/scaled_normalizer_pkg.sv
// Shared definitions for the scaled-word encoder: widths, packed word type, FSM states.
// The scaled word is {scale, mantissa}; value = signed mantissa / 2^scale.
package scaled_normalizer_pkg;

  localparam int RAW_W   = 20;
  localparam int MANT_W  = 13;
  localparam int SCALE_W = 3;
  localparam int WORD_W  = SCALE_W + MANT_W;
  // One guard bit above the raw width so a rounding increment of the largest raw value cannot wrap.
  localparam int ACC_W   = RAW_W + 1;

  localparam int MANT_MAX = 4095;
  localparam int MANT_MIN = -4096;

  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [MANT_W-1:0]  mantissa;
  } scaled_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_OUT  = 2'd2
  } norm_state_t;

  function automatic scaled_word_t pack_word(input logic [SCALE_W-1:0] scale,
                                             input logic [MANT_W-1:0]  mantissa);
    scaled_word_t w;
    w.scale    = scale;
    w.mantissa = mantissa;
    return w;
  endfunction

endpackage

// File: rtl/scaled_normalizer_if.sv
// Operand/result handshake bundle for the scaled-word encoder.
// master drives operands and consumes results; slave is the encoder itself.
interface scaled_normalizer_if;
  import scaled_normalizer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [RAW_W-1:0]   in_raw;
  logic [SCALE_W-1:0] in_scale;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out;
  logic               invalid;

  modport master (
    output in_valid, in_raw, in_scale, out_ready,
    input  in_ready, out_valid, out, invalid
  );

  modport slave (
    input  in_valid, in_raw, in_scale, out_ready,
    output in_ready, out_valid, out, invalid
  );

endinterface

// File: rtl/scaled_normalizer_fit_check.sv
// Combinational test: does a signed accumulator fit in a MANT_W-bit signed mantissa?
// True when every bit from the mantissa sign bit upward is a copy of the sign.
module scaled_fit_check
  import scaled_normalizer_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] acc,
  output logic         fits
);

  logic [W-MANT_W:0] upper;

  always_comb begin
    upper = acc[W-1:MANT_W-1];
    fits  = (&upper) | ~(|upper);
  end

endmodule

// File: rtl/scaled_normalizer.sv
// Packs a 20-bit signed raw value with a scale into a legal {scale, mantissa} word.
// Define NORM_ROUND_EN to make each shift round half-up instead of truncating.
//
// state | meaning
// IDLE  | ready for an operand; latches raw/scale on in_valid
// NORM  | one arithmetic right shift per cycle until the value fits or scale hits 0
// OUT   | result held on out/invalid until out_ready
module scaled_normalizer
  import scaled_normalizer_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  scaled_normalizer_if.slave  bus
);

  norm_state_t              state;
  logic signed [ACC_W-1:0]  acc;
  logic [SCALE_W-1:0]       sc;
  logic                     fits;
  logic signed [ACC_W-1:0]  acc_next;
  scaled_word_t             word;
  logic                     in_ready;
  logic                     out_valid;
  logic                     invalid;

  scaled_fit_check #(.W(ACC_W)) u_fit (
    .acc  (acc),
    .fits (fits)
  );

`ifdef NORM_ROUND_EN
  logic signed [ACC_W-1:0] acc_inc;

  always_comb begin
    acc_inc  = acc + ACC_W'(1);
    acc_next = acc_inc >>> 1;
  end
`else
  always_comb begin
    acc_next = acc >>> 1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      sc        <= '0;
      word      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc      <= {bus.in_raw[RAW_W-1], bus.in_raw};
            sc       <= bus.in_scale;
            in_ready <= 1'b0;
            state    <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (fits) begin
            word      <= pack_word(sc, acc[MANT_W-1:0]);
            invalid   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else if (sc == '0) begin
            // Out of scale headroom: emit the truncated mantissa and flag it.
            word      <= pack_word('0, acc[MANT_W-1:0]);
            invalid   <= 1'b1;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            acc <= acc_next;
            sc  <= sc - SCALE_W'(1);
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = word;
  assign bus.invalid   = invalid;

endmodule

// File: tb/tb_scaled_normalizer.sv
// Self-checking bench for scaled_normalizer: vector table through a scoreboard queue,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_scaled_normalizer;

  logic clk;
  logic rst;

  scaled_normalizer_if bus ();

  scaled_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] raw;
    logic [2:0]  scale;
    logic [15:0] exp_out;
    logic        exp_inv;
    int          k;
  } vec_t;

  typedef struct {
    logic [15:0] exp_out;
    logic        exp_inv;
    int          lat;
  } exp_t;

  vec_t vecs [12];
  exp_t exp_q [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Offers one operand, waits for its result, checks against the scoreboard entry.
  task automatic send(input logic [19:0] raw, input logic [2:0] scale,
                      input logic [15:0] eo, input logic ei, input int k);
    int cyc;
    exp_t e;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_raw   = raw;
    bus.in_scale = scale;
    bus.in_valid = 1'b1;
    exp_q.push_back('{eo, ei, k + 2});
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    chk("latency", cyc, e.lat);
    chk("out_word", {16'd0, bus.out}, {16'd0, e.exp_out});
    chk("invalid", {31'd0, bus.invalid}, {31'd0, e.exp_inv});
    chk("in_ready_low_in_out", {31'd0, bus.in_ready}, 32'd0);
  endtask

  logic [15:0] held_out;
  logic        held_inv;

  initial begin
    vecs[0]  = '{20'd1000,   3'd5, 16'hA3E8, 1'b0, 0};
    vecs[1]  = '{20'd20000,  3'd6, 16'h69C4, 1'b0, 3};
    vecs[2]  = '{20'hFB1E0,  3'd6, 16'h763C, 1'b0, 3};   // -20000
    vecs[3]  = '{20'd0,      3'd3, 16'h6000, 1'b0, 0};
    vecs[4]  = '{20'hFF000,  3'd0, 16'h1000, 1'b0, 0};   // -4096 fits
    vecs[5]  = '{20'd4096,   3'd0, 16'h1000, 1'b1, 0};   // 4096 with no headroom
    vecs[6]  = '{20'hFFFFF,  3'd7, 16'hFFFF, 1'b0, 0};   // -1
    vecs[7]  = '{20'd4096,   3'd7, 16'hC800, 1'b0, 1};
    vecs[8]  = '{20'hFFFFE,  3'd4, 16'h9FFE, 1'b0, 0};   // -2 fits directly
`ifdef NORM_ROUND_EN
    vecs[9]  = '{20'h7FFFF,  3'd2, 16'h0000, 1'b1, 2};
    vecs[10] = '{20'd8191,   3'd1, 16'h1000, 1'b1, 1};
    vecs[11] = '{20'hFEFFF,  3'd4, 16'h7800, 1'b0, 1};   // -4097 rounds to -2048
`else
    vecs[9]  = '{20'h7FFFF,  3'd2, 16'h1FFF, 1'b1, 2};
    vecs[10] = '{20'd8191,   3'd1, 16'h0FFF, 1'b0, 1};
    vecs[11] = '{20'hFEFFF,  3'd4, 16'h77FF, 1'b0, 1};   // -4097 -> -2049
`endif

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_raw   = '0;
    bus.in_scale = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out", {16'd0, bus.out}, 32'd0);
    chk("reset_invalid", {31'd0, bus.invalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].raw, vecs[i].scale, vecs[i].exp_out, vecs[i].exp_inv, vecs[i].k);
      @(posedge clk);
      @(negedge clk);
      chk("idle_after_out", {31'd0, bus.in_ready}, 32'd1);
    end

    // Backpressure: result must hold while out_ready is low; a pending offer is ignored.
    bus.out_ready = 1'b0;
    send(20'd20000, 3'd6, 16'h69C4, 1'b0, 3);
    held_out = bus.out;
    held_inv = bus.invalid;
    bus.in_raw   = 20'd77;
    bus.in_scale = 3'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out", {16'd0, bus.out}, {16'd0, held_out});
      chk("bp_invalid", {31'd0, bus.invalid}, {31'd0, held_inv});
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(20'd1000, 3'd5, 16'hA3E8, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);

    // Reset during NORM aborts the operand with no output.
    bus.in_raw   = 20'd20000;
    bus.in_scale = 3'd6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("norm_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_output", {31'd0, bus.out_valid}, 32'd0);
    end
    send(20'd1000, 3'd5, 16'hA3E8, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
